// File: rtl/dec_select_arbiter.sv
// Round-robin arbiter that shares one 1-of-4 decoder among four requesters.
// Drives the decoder select lines (b/a) and its active-low enable (g_).
// Between owners the enable is held high for GAP cycles (break-before-make).
// MAXHOLD bounds how long one owner may hold the decoder while others wait.
//
// Handshake: req[i] is a level-sensitive request. gnt[i] high means requester i
// owns the decoder for that cycle. The grant is held while req[i] stays high,
// unless it is preempted by the hold limit. A requester releases by dropping
// req[i]; a preempted requester simply keeps req[i] high and is served again
// in rotation.
module dec_select_arbiter #(
    parameter int MAXHOLD = 8,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       b,
    output logic       a,
    output logic       g_,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Last value cnt may reach before a pending request forces a release.
    localparam logic [7:0] HOLD_LAST = (MAXHOLD == 0) ? 8'd0 : 8'(MAXHOLD - 1);
    // Gap counter preload; GAP cycles of g_ high means GAP-1 decrements.
    localparam logic [1:0] GAP_INIT  = (GAP == 0) ? 2'd0 : 2'(GAP - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] gapcnt, gapcnt_n;
    logic [1:0] sel_n;
    logic       g_n;
    logic [3:0] gnt_n;
    logic       busy_n;

    logic [1:0] owner;
    logic [3:0] others;
    logic       release_now;
    logic [2:0] win_ptr;   // {found, index} searching from ptr
    logic [2:0] win_next;  // {found, index} searching from owner+1

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // First set request bit found at p, p+1, ... (mod 4); MSB flags a hit.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) pick = {1'b1, idx};
        end
    endfunction

    assign owner       = {b, a};
    assign others      = req & ~onehot(owner);
    assign win_ptr     = pick(req, ptr);
    assign win_next    = pick(req, owner + 2'd1);
    assign release_now = !req[owner] ||
                         ((MAXHOLD != 0) && (cnt == HOLD_LAST) &&
                          (others != 4'b0000) && !lock);

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        gapcnt_n = gapcnt;
        sel_n    = owner;
        g_n      = g_;
        gnt_n    = gnt;
        case (state)
            ST_IDLE: begin
                if (win_ptr[2]) begin
                    state_n = ST_GRANT;
                    sel_n   = win_ptr[1:0];
                    g_n     = 1'b0;
                    gnt_n   = onehot(win_ptr[1:0]);
                    cnt_n   = 8'd0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_n = owner + 2'd1;
                    if (GAP != 0) begin
                        state_n  = ST_GAP;
                        g_n      = 1'b1;
                        gnt_n    = 4'b0000;
                        gapcnt_n = GAP_INIT;
                    end else if (win_next[2]) begin
                        // Hand over directly; the search starts past the old owner.
                        sel_n = win_next[1:0];
                        g_n   = 1'b0;
                        gnt_n = onehot(win_next[1:0]);
                        cnt_n = 8'd0;
                    end else begin
                        state_n = ST_IDLE;
                        g_n     = 1'b1;
                        gnt_n   = 4'b0000;
                    end
                end else if ((MAXHOLD != 0) && (others != 4'b0000) &&
                             (cnt != HOLD_LAST)) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (gapcnt != 2'd0) begin
                    gapcnt_n = gapcnt - 2'd1;
                end else if (win_ptr[2]) begin
                    state_n = ST_GRANT;
                    sel_n   = win_ptr[1:0];
                    g_n     = 1'b0;
                    gnt_n   = onehot(win_ptr[1:0]);
                    cnt_n   = 8'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                g_n     = 1'b1;
                gnt_n   = 4'b0000;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs; reset disables the decoder immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= 2'd0;
            cnt    <= 8'd0;
            gapcnt <= 2'd0;
            b      <= 1'b0;
            a      <= 1'b0;
            g_     <= 1'b1;
            gnt    <= 4'b0000;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            gapcnt <= gapcnt_n;
            b      <= sel_n[1];
            a      <= sel_n[0];
            g_     <= g_n;
            gnt    <= gnt_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_dec_select_arbiter.sv
// Bench for dec_select_arbiter: three parameterisations share one clock/reset.
// Expected grant episodes {instance, owner, length} go into exp_q as stimulus
// is issued; the monitor closes an episode when g_ rises or the owner changes.
module tb_dec_select_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_v  [3];
  logic [2:0] lock_v;
  logic [2:0] b_v, a_v, g_v, busy_v;
  logic [3:0] gnt_v  [3];

  int tests_run;
  int tests_failed;

  logic [15:0] exp_q[$];

  int         ep_len [3];
  logic [1:0] ep_own [3];
  logic       ep_act [3];

  // u0: default limits, u1: no gap, u2: unlimited hold
  dec_select_arbiter #(.MAXHOLD(8), .GAP(1)) u0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .lock(lock_v[0]),
    .b(b_v[0]), .a(a_v[0]), .g_(g_v[0]), .gnt(gnt_v[0]), .busy(busy_v[0]));
  dec_select_arbiter #(.MAXHOLD(8), .GAP(0)) u1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .lock(lock_v[1]),
    .b(b_v[1]), .a(a_v[1]), .g_(g_v[1]), .gnt(gnt_v[1]), .busy(busy_v[1]));
  dec_select_arbiter #(.MAXHOLD(0), .GAP(1)) u2 (
    .clk(clk), .rst(rst), .req(req_v[2]), .lock(lock_v[2]),
    .b(b_v[2]), .a(a_v[2]), .g_(g_v[2]), .gnt(gnt_v[2]), .busy(busy_v[2]));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int inst, input logic [1:0] own, input int len);
    exp_q.push_back({2'(inst), own, 12'(len)});
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic check_out(input int k, input string name, input logic gx,
                           input logic [1:0] bax, input logic [3:0] gntx);
    check({name, "_g"}, 16'(g_v[k]), 16'(gx));
    check({name, "_ba"}, 16'({b_v[k], a_v[k]}), 16'(bax));
    check({name, "_gnt"}, 16'(gnt_v[k]), 16'(gntx));
  endtask

  // monitor: grant/enable consistency every cycle, episode scoreboard
  always @(negedge clk) begin
    logic [3:0]  exp_gnt;
    logic [15:0] rec;
    logic [15:0] exp_rec;
    for (int k = 0; k < 3; k++) begin
      exp_gnt = g_v[k] ? 4'b0000 : (4'b0001 << {b_v[k], a_v[k]});
      check("gnt_vs_sel", 16'(gnt_v[k]), 16'(exp_gnt));
      if (ep_act[k] && (g_v[k] || ep_own[k] != {b_v[k], a_v[k]})) begin
        rec = {2'(k), ep_own[k], 12'(ep_len[k])};
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL episode: got %0h expected none (queue empty)", rec);
        end else begin
          exp_rec = exp_q.pop_front();
          check("episode", rec, exp_rec);
        end
        ep_act[k] = 1'b0;
      end
      if (!g_v[k]) begin
        if (ep_act[k]) begin
          ep_len[k] = ep_len[k] + 1;
        end else begin
          ep_act[k] = 1'b1;
          ep_own[k] = {b_v[k], a_v[k]};
          ep_len[k] = 1;
        end
      end
    end
  end

  // driver: directed phases
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int k = 0; k < 3; k++) begin
      req_v[k]  = 4'b0000;
      ep_len[k] = 0;
      ep_own[k] = 2'd0;
      ep_act[k] = 1'b0;
    end
    lock_v = 3'b000;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_out(0, "reset", 1'b1, 2'd0, 4'b0000);
    check("reset_busy", 16'(busy_v[0]), 16'd0);
    tick(1);
    rst = 1'b0;

    // single requester, then release through one gap cycle
    push(0, 2'd0, 4);
    req_v[0] = 4'b0001;
    tick(1);
    check_out(0, "first_grant", 1'b0, 2'd0, 4'b0001);
    check("first_busy", 16'(busy_v[0]), 16'd1);
    tick(3);
    req_v[0] = 4'b0000;
    tick(1);
    check("gap_g", 16'(g_v[0]), 16'd1);
    check("gap_busy", 16'(busy_v[0]), 16'd1);
    tick(1);
    check("idle_busy", 16'(busy_v[0]), 16'd0);
    check("idle_g", 16'(g_v[0]), 16'd1);

    // all four requesting: rotation 0,1,2,3 each held 8 cycles, then 0 again
    pulse_rst();
    push(0, 2'd0, 8);
    push(0, 2'd1, 8);
    push(0, 2'd2, 8);
    push(0, 2'd3, 8);
    push(0, 2'd0, 3);
    req_v[0] = 4'b1111;
    tick(37);
    check_out(0, "rotate_wrap", 1'b0, 2'd0, 4'b0001);
    tick(2);
    req_v[0] = 4'b0000;
    tick(3);

    // lock extends owner 2 beyond the hold limit; next owner wraps to 1
    pulse_rst();
    push(0, 2'd2, 21);
    push(0, 2'd1, 3);
    req_v[0]  = 4'b0100;
    lock_v[0] = 1'b1;
    tick(1);
    check_out(0, "lock_start", 1'b0, 2'd2, 4'b0100);
    req_v[0] = 4'b0110;
    tick(20);
    check_out(0, "lock_hold", 1'b0, 2'd2, 4'b0100);
    lock_v[0] = 1'b0;
    tick(1);
    check_out(0, "unlock_gap", 1'b1, 2'd2, 4'b0000);
    tick(1);
    check_out(0, "unlock_next", 1'b0, 2'd1, 4'b0010);
    tick(2);
    req_v[0] = 4'b0000;
    tick(3);

    // zero gap: direct handover 0 -> 1 without enable going high
    pulse_rst();
    push(1, 2'd0, 3);
    push(1, 2'd1, 2);
    req_v[1] = 4'b0011;
    tick(3);
    req_v[1] = 4'b0010;
    tick(1);
    check_out(1, "nogap_handover", 1'b0, 2'd1, 4'b0010);
    tick(1);
    req_v[1] = 4'b0000;
    tick(1);
    check_out(1, "nogap_idle", 1'b1, 2'd1, 4'b0000);
    check("nogap_busy", 16'(busy_v[1]), 16'd0);
    tick(2);

    // asynchronous reset in the middle of a grant, then re-grant of 2
    pulse_rst();
    push(0, 2'd2, 2);
    push(0, 2'd2, 2);
    req_v[0] = 4'b0100;
    tick(1);
    check_out(0, "pre_reset", 1'b0, 2'd2, 4'b0100);
    tick(2);
    #2 rst = 1'b1;
    #1;
    check_out(0, "async_reset", 1'b1, 2'd0, 4'b0000);
    check("async_reset_busy", 16'(busy_v[0]), 16'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check_out(0, "post_reset", 1'b0, 2'd2, 4'b0100);
    tick(1);
    req_v[0] = 4'b0000;
    tick(3);

    // unlimited hold: owner 0 keeps the decoder for 50 cycles despite req 2
    pulse_rst();
    push(2, 2'd0, 50);
    push(2, 2'd2, 2);
    req_v[2] = 4'b0101;
    tick(50);
    check_out(2, "unlimited_hold", 1'b0, 2'd0, 4'b0001);
    req_v[2] = 4'b0100;
    tick(1);
    check("unlimited_gap_g", 16'(g_v[2]), 16'd1);
    check("unlimited_gap_busy", 16'(busy_v[2]), 16'd1);
    tick(1);
    check_out(2, "unlimited_next", 1'b0, 2'd2, 4'b0100);
    tick(1);
    req_v[2] = 4'b0000;
    tick(3);

    // final report
    tick(2);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dec_select_arbiter.md
Name: dec_select_arbiter

Overview:
- Round-robin arbiter sharing one 1-of-4 decoder (74LS139-class) among four requesters.
- Drives the decoder select inputs b/a and the active-low enable g_; one-hot gnt to requesters.
- Break-before-make: decoder disabled for a programmable gap between owners; hold-time limit prevents starvation.
- Sits between bus-master request logic and the decoder half it controls.

Parameters:
- MAXHOLD, 8, max consecutive grant cycles while another request is pending; 0 = unlimited; range 0..255.
- GAP, 1, cycles g_ is forced high between consecutive owners; range 0..3.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  4  request, bit i = requester i, active-high, level-sensitive
- lock  in  1  current owner suppresses MAXHOLD preemption, active-high
- b  out  1  decoder select MSB (owner index bit 1)
- a  out  1  decoder select LSB (owner index bit 0)
- g_  out  1  decoder enable, active-low
- gnt  out  4  one-hot grant, equals decode of {b,a} when g_=0, else 0
- busy  out  1  high in GRANT or GAP state

Behaviour:
- All outputs registered. States IDLE, GRANT, GAP.
- Reset (async, immediate, also mid-grant): state=IDLE, ptr=0, cnt=0, gapcnt=0, g_=1, b=a=0, gnt=0, busy=0.
- Arbitration: winner = first set req bit searching ptr, ptr+1, ... mod 4. ptr is the 2-bit round-robin pointer.
- IDLE: if req!=0 at edge, next state GRANT; {b,a}=winner, g_=0, gnt=onehot(winner), cnt=0. Latency: 1 clock from req sampled to g_ low. If req=0, stay; b/a hold last value.
- GRANT, owner o:
  - Release condition at edge: req[o]=0, OR (MAXHOLD!=0 AND cnt==MAXHOLD-1 AND (req & ~onehot(o))!=0 AND lock=0).
  - No release: cnt increments only while another req pending, saturating at MAXHOLD-1; cnt held otherwise.
  - On release: ptr=o+1 mod 4.
    - GAP>0: state GAP, g_=1, gnt=0, b/a hold o, gapcnt=GAP-1.
    - GAP=0: arbitrate immediately with new ptr. Winner exists -> stay GRANT with new owner, cnt=0. Otherwise -> IDLE, g_=1, gnt=0.
- GAP: g_=1 for exactly GAP cycles.
  - While gapcnt!=0: decrement.
  - When gapcnt==0: arbitrate with req at that edge -> GRANT (new owner) or IDLE.
- Preempted owner keeps its req asserted and is re-served in rotation. Own request never re-wins over pending others because ptr advanced past it.
- req bit dropping for a non-owner has no effect. New req arriving mid-GRANT waits for release.
- lock=1 with only the owner requesting: no effect. lock sampled every GRANT cycle; deasserting lock at cnt==MAXHOLD-1 preempts at that edge.
- Invariant: g_=0 iff state GRANT; gnt never has more than one bit set; gnt=0 whenever g_=1.

Test Plan:
- Reset then req=0001 -> 1 cycle later g_=0, {b,a}=00, gnt=0001, busy=1. req=0000 -> g_=1 for 1 cycle (GAP=1), then IDLE, busy=0.
- req=1111 held, MAXHOLD=8, GAP=1 -> owners 0,1,2,3,0 in order. Each g_ low exactly 8 cycles, 1-cycle g_ high gap between owners, gnt one-hot matching {b,a}.
- Owner 2 granted, lock=1, req=0110 -> owner 2 holds beyond 8 cycles. Drop lock -> release at next edge where cnt==7, next owner 1 (pointer wraps 3->0->1).
- GAP=0, req=0011, owner 0 drops req -> next clock gnt=0010, g_ stays 0, {b,a}=01, no high gap.
- Assert rst mid-grant (gnt=0100) -> g_=1, gnt=0, b=a=0, busy=0 immediately without a clock edge. Release rst with req=0100 -> grant 2 one clock later (ptr=0, search 0..2).
- MAXHOLD=0, req=0101 held 50 cycles -> owner 0 keeps grant all 50 cycles. Drop req[0] -> owner 2 after gap.
